// File: rtl/traffic_light_fsm_if.sv
// Timer handshake between the traffic light controller (master) and the
// 8-bit down-counter timer (slave).
interface traffic_light_fsm_if;
  logic       load;
  logic [7:0] value;
  logic       decr;
  logic       timeup;

  modport master (output load, output value, output decr, input timeup);
  modport slave  (input load, input value, input decr, output timeup);
endinterface

// File: rtl/traffic_light_fsm.sv
// Phase controller for a main/side road intersection driving an external down-counter timer.
// Define PED_WALK_EN to enable the pedestrian walk phase between ALL_RED_1 and the side phase.
module traffic_light_fsm #(
  parameter logic [7:0] T_MAIN_GREEN = 8'd20,
  parameter logic [7:0] T_YELLOW     = 8'd4,
  parameter logic [7:0] T_ALL_RED    = 8'd2,
  parameter logic [7:0] T_SIDE_GREEN = 8'd10,
  parameter logic [7:0] T_WALK       = 8'd8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_side_car,
  input  logic                i_ped_req,
  traffic_light_fsm_if.master tmr,
  output logic [2:0]          o_main_light,
  output logic [2:0]          o_side_light,
  output logic                o_walk,
  output logic [2:0]          o_state_dbg
);

  typedef enum logic [2:0] {
    S_MAIN_GREEN  = 3'd0,
    S_MAIN_YELLOW = 3'd1,
    S_ALL_RED_1   = 3'd2,
    S_SIDE_GREEN  = 3'd3,
    S_SIDE_YELLOW = 3'd4,
    S_ALL_RED_2   = 3'd5,
    S_PED_WALK    = 3'd6
  } state_t;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

  state_t     r_state;
  state_t     w_next;
  logic       r_first;
  logic       r_car_pend;
  logic       r_ped_pend;
  logic       w_adv;
  logic       w_enter_side;
  logic [7:0] w_value;
`ifdef PED_WALK_EN
  logic       w_enter_walk;
`endif

  // The timer still holds its stale count during the load cycle, so timeup only counts after it.
  assign w_adv = ~r_first & tmr.timeup;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = S_ALL_RED_2;
    case (r_state)
      S_MAIN_GREEN:  w_next = (w_adv && (r_car_pend || r_ped_pend)) ? S_MAIN_YELLOW : S_MAIN_GREEN;
      S_MAIN_YELLOW: w_next = w_adv ? S_ALL_RED_1 : S_MAIN_YELLOW;
      S_ALL_RED_1: begin
        w_next = w_adv ? S_SIDE_GREEN : S_ALL_RED_1;
`ifdef PED_WALK_EN
        if (w_adv && r_ped_pend) w_next = S_PED_WALK;
`endif
      end
      S_SIDE_GREEN:  w_next = w_adv ? S_SIDE_YELLOW : S_SIDE_GREEN;
      S_SIDE_YELLOW: w_next = w_adv ? S_ALL_RED_2 : S_SIDE_YELLOW;
      S_ALL_RED_2:   w_next = w_adv ? S_MAIN_GREEN : S_ALL_RED_2;
`ifdef PED_WALK_EN
      S_PED_WALK:    w_next = w_adv ? (r_car_pend ? S_SIDE_GREEN : S_ALL_RED_2) : S_PED_WALK;
`endif
      default:       w_next = S_ALL_RED_2;
    endcase
  end

  assign w_enter_side = (w_next == S_SIDE_GREEN) && (r_state != S_SIDE_GREEN);
`ifdef PED_WALK_EN
  assign w_enter_walk = (w_next == S_PED_WALK) && (r_state != S_PED_WALK);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_MAIN_GREEN;
      r_first    <= 1'b1;
      r_car_pend <= 1'b0;
      r_ped_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      // Illegal encodings always differ from ALL_RED_2, so they reload too.
      r_first <= (w_next != r_state);

      // Clear has priority over a request arriving in the same cycle.
      if (w_enter_side)    r_car_pend <= 1'b0;
      else if (i_side_car) r_car_pend <= 1'b1;

`ifdef PED_WALK_EN
      if (w_enter_walk)    r_ped_pend <= 1'b0;
`else
      if (w_enter_side)    r_ped_pend <= 1'b0;
`endif
      else if (i_ped_req)  r_ped_pend <= 1'b1;
    end
  end

  always_comb begin
    o_main_light = L_RED;
    o_side_light = L_RED;
    w_value      = 8'd0;
    case (r_state)
      S_MAIN_GREEN: begin
        o_main_light = L_GREEN;
        w_value      = T_MAIN_GREEN;
      end
      S_MAIN_YELLOW: begin
        o_main_light = L_YELLOW;
        w_value      = T_YELLOW;
      end
      S_ALL_RED_1, S_ALL_RED_2: w_value = T_ALL_RED;
      S_SIDE_GREEN: begin
        o_side_light = L_GREEN;
        w_value      = T_SIDE_GREEN;
      end
      S_SIDE_YELLOW: begin
        o_side_light = L_YELLOW;
        w_value      = T_YELLOW;
      end
      S_PED_WALK:   w_value = T_WALK;
      default:      w_value = 8'd0;
    endcase
  end

`ifdef PED_WALK_EN
  assign o_walk = (r_state == S_PED_WALK);
`else
  assign o_walk = 1'b0;
`endif

  assign tmr.load    = r_first;
  assign tmr.decr    = ~r_first;
  assign tmr.value   = w_value;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm with a behavioural down-counter timer attached.
// Expected per-cycle outputs are queued from the dwell table and compared each cycle.
module tb_traffic_light_fsm;
  localparam logic [7:0] P_MG = 8'd4;
  localparam logic [7:0] P_Y  = 8'd2;
  localparam logic [7:0] P_AR = 8'd1;
  localparam logic [7:0] P_SG = 8'd3;
  localparam logic [7:0] P_W  = 8'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       side_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light, side_light, state_dbg;
  logic       walk;
  logic [7:0] r_count;

  traffic_light_fsm_if tmr_if();

  traffic_light_fsm #(
    .T_MAIN_GREEN(P_MG), .T_YELLOW(P_Y), .T_ALL_RED(P_AR),
    .T_SIDE_GREEN(P_SG), .T_WALK(P_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_side_car   (side_car),
    .i_ped_req    (ped_req),
    .tmr          (tmr_if),
    .o_main_light (main_light),
    .o_side_light (side_light),
    .o_walk       (walk),
    .o_state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Down-counter timer: load wins, decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (reset)                               r_count <= 8'd0;
    else if (tmr_if.load)                    r_count <= tmr_if.value;
    else if (tmr_if.decr && r_count != 8'd0) r_count <= r_count - 8'd1;
  end
  assign tmr_if.timeup = (r_count == 8'd0);

  typedef struct {
    int         st;
    logic       ld;
    logic       dec;
    logic       tu;
    logic       wk;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] dwell(input int s);
    case (s)
      0: return P_MG;
      1: return P_Y;
      2: return P_AR;
      3: return P_SG;
      4: return P_Y;
      5: return P_AR;
      6: return P_W;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] exp_main(input int s);
    case (s)
      0: return 3'b001;
      1: return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input int s);
    case (s)
      3: return 3'b001;
      4: return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Queue n cycles of state s: load on entry, decrement after, timeup at entry (stale 0) and once drained.
  task automatic push_phase(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.st  = s;
      e.ld  = (i == 0);
      e.dec = (i != 0);
      e.val = dwell(s);
      e.tu  = (i == 0) || (i >= int'(dwell(s)) + 1);
      e.wk  = (s == 6);
      sb.push_back(e);
    end
  endtask

  task automatic push_loop();
    push_phase(0, 6); push_phase(1, 4); push_phase(2, 3);
    push_phase(3, 5); push_phase(4, 4); push_phase(5, 3);
  endtask

  // Called at a falling edge: compare this cycle's outputs, then drive inputs for the coming edge.
  task automatic step(input logic car, input logic ped);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("state_dbg",  32'(state_dbg),      32'(e.st));
      check("main_light", 32'(main_light),     32'(exp_main(e.st)));
      check("side_light", 32'(side_light),     32'(exp_side(e.st)));
      check("load",       32'(tmr_if.load),    32'(e.ld));
      check("decr",       32'(tmr_if.decr),    32'(e.dec));
      check("value",      32'(tmr_if.value),   32'(e.val));
      check("timeup",     32'(tmr_if.timeup),  32'(e.tu));
      check("walk",       32'(walk),           32'(e.wk));
      if (e.st == 3 && e.ld) check("car_pend_at_side_entry", 32'(dut.r_car_pend), 32'd0);
    end
    check("both_roads_open", 32'((main_light != 3'b100) && (side_light != 3'b100)), 32'd0);
    side_car = car;
    ped_req  = ped;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    side_car = 1'b0;
    ped_req  = 1'b0;
    reset    = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Idle: no requests, main green holds with a single load pulse.
    do_reset(3);
    push_phase(0, 50);
    repeat (50) step(1'b0, 1'b0);
    check("idle_drained", 32'(sb.size()), 32'd0);

    // One-cycle car pulse at cycle 2 runs one full side cycle, then main green holds.
    do_reset(3);
    push_loop();
    push_phase(0, 8);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    check("car_pulse_drained", 32'(sb.size()), 32'd0);

    // Car held continuously: the full cycle repeats back to back.
    do_reset(3);
    push_loop();
    push_loop();
    repeat (50) step(1'b1, 1'b0);
    check("car_held_drained", 32'(sb.size()), 32'd0);

    // Pedestrian-only pulse.
    do_reset(3);
    push_phase(0, 6); push_phase(1, 4); push_phase(2, 3);
`ifdef PED_WALK_EN
    push_phase(6, 4);
`else
    push_phase(3, 5); push_phase(4, 4);
`endif
    push_phase(5, 3);
    push_phase(0, 8);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    while (sb.size() > 0) step(1'b0, 1'b0);

    // Reset asserted mid side-green with both requests latched.
    do_reset(3);
    push_phase(0, 6); push_phase(1, 4); push_phase(2, 3); push_phase(3, 3);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    repeat (11) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("car_pend_relatched", 32'(dut.r_car_pend), 32'd1);
    check("ped_pend_relatched", 32'(dut.r_ped_pend), 32'd1);
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    cyc   = 0;
    check("car_pend_after_reset", 32'(dut.r_car_pend), 32'd0);
    check("ped_pend_after_reset", 32'(dut.r_ped_pend), 32'd0);
    push_phase(0, 6);
    repeat (6) step(1'b0, 1'b0);
    check("reset_mid_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Phase controller for a two-road intersection: main road and side road.
- Sits directly upstream of the 8-bit down-counter timer. Drives the timer's load, value and decr inputs and consumes its timeup output.
- Sequences main and side lights through green, yellow and all-red phases, driven by latched side-road car and pedestrian requests.
- Light outputs are Moore-decoded from the registered state.

Parameters:
T_MAIN_GREEN, 8'd20, minimum main-green dwell value loaded into timer
T_YELLOW, 8'd4, yellow dwell value (both roads)
T_ALL_RED, 8'd2, all-red clearance dwell value
T_SIDE_GREEN, 8'd10, side-green dwell value
T_WALK, 8'd8, pedestrian walk dwell value (used only with PED_WALK_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
side_car  input  1  side-road vehicle sensor, level, sampled every cycle
ped_req  input  1  pedestrian button, level, sampled every cycle
timeup  input  1  from timer, high when timer count == 0
load  output  1  timer load strobe, one cycle at each state entry
value  output  8  timer reload value for current state, valid when load=1
decr  output  1  timer decrement enable
main_light  output  3  {red,yellow,green} one-hot, main road
side_light  output  3  {red,yellow,green} one-hot, side road
walk  output  1  pedestrian walk lamp
state_dbg  output  3  current state encoding, for debug and bench

Behaviour:
- States and encodings: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_1=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_2=5, PED_WALK=6.
- Registers: state, entry flag `first`, car_pend, ped_pend.
- Reset, sampled at the clk edge while reset=1:
  - state=MAIN_GREEN, first=1, car_pend=0, ped_pend=0.
  - Outputs therefore read: main_light=001, side_light=100, walk=0, load=1, value=T_MAIN_GREEN, decr=0, state_dbg=0.
- Timer handshake:
  - load = first.
  - decr = ~first.
  - value = dwell parameter of the current state, driven in every state (not only when load=1).
  - `first` is set on every state transition and cleared in the next cycle.
  - timeup is ignored while first=1, because the timer still holds its stale count in that cycle.
- Dwell: a state with value N lasts N+2 cycles (1 load cycle, N decrement cycles, 1 cycle seeing timeup) before the transition edge. N=0 gives 2 cycles.
- Transitions (all require first=0 and timeup=1):
  - MAIN_GREEN -> MAIN_YELLOW only if (car_pend | ped_pend) is set in that same cycle. Otherwise stay, with no reload; the timer remains at 0.
  - MAIN_YELLOW -> ALL_RED_1.
  - ALL_RED_1 -> SIDE_GREEN.
  - SIDE_GREEN -> SIDE_YELLOW.
  - SIDE_YELLOW -> ALL_RED_2.
  - ALL_RED_2 -> MAIN_GREEN.
- Request latches:
  - car_pend is set when side_car=1 and cleared on the transition into SIDE_GREEN. A set and a clear in the same cycle resolve to clear.
  - ped_pend is set when ped_req=1 and cleared on the transition into PED_WALK. Without the feature, ped_pend is cleared on entry to SIDE_GREEN.
  - A request arriving during SIDE_GREEN or later re-latches and is served in the next cycle of the sequence.
- Light decode:
  - MAIN_GREEN: main=001, side=100.
  - MAIN_YELLOW: main=010, side=100.
  - ALL_RED_1, ALL_RED_2, PED_WALK: main=100, side=100.
  - SIDE_GREEN: main=100, side=001.
  - SIDE_YELLOW: main=100, side=010.
  - Never both greens, never a green or yellow on both roads at once.
- Safety: an unused or illegal state encoding goes to ALL_RED_2 with first=1. The light decode for an illegal state is all red.
- Reset mid-phase: overrides everything. Next cycle is MAIN_GREEN with first=1; both latches cleared.

Optional Feature:
- Macro: PED_WALK_EN.
- When defined:
  - ALL_RED_1 exit goes to PED_WALK if ped_pend=1, else to SIDE_GREEN.
  - PED_WALK: walk=1, all red, value=T_WALK.
  - PED_WALK exit goes to SIDE_GREEN if car_pend=1, else to ALL_RED_2.
  - A ped-only request never shows side green.
- When undefined:
  - PED_WALK is unreachable and treated as illegal.
  - walk is tied to 0.
  - ped_req still latches ped_pend and still triggers the MAIN_GREEN exit.

Test Plan:
- Common setup: the bench instantiates the real timer, with T_MAIN_GREEN=4, T_YELLOW=2, T_ALL_RED=1, T_SIDE_GREEN=3, T_WALK=2.
- Reset held 3 cycles then released -> load=1, value=4, main_light=001 in the cycle after release; load=0, decr=1 next.
- No requests for 50 cycles -> state_dbg stays 0, load pulses exactly once, timeup stays 1 from cycle 6 onward.
- side_car pulsed 1 cycle at cycle 2 -> MAIN_GREEN exits after 6 cycles. Then MAIN_YELLOW 4, ALL_RED_1 3, SIDE_GREEN 5, SIDE_YELLOW 4, ALL_RED_2 3 cycles, then back to MAIN_GREEN. car_pend is clear at SIDE_GREEN entry.
- side_car held high continuously -> cycles repeat. At every cycle main_light and side_light are never both non-red.
- PED_WALK_EN build, ped_req pulse only -> sequence MAIN_YELLOW, ALL_RED_1, PED_WALK (walk=1 for 4 cycles), ALL_RED_2, MAIN_GREEN. side_light is never 001.
- Reset asserted during SIDE_GREEN -> next cycle main_light=001, load=1, value=4, latches cleared.
